// File: rtl/tickgen_pkg.sv
// Shared constants, config FSM state type and increment calculator for the
// NCO-based UART tick generator.
package tickgen_pkg;

  localparam longint unsigned CLK_HZ             = 64'd100_000_000;
  localparam longint unsigned DEFAULT_BAUD       = 64'd115_200;
  localparam longint unsigned DEFAULT_OVERSAMPLE = 64'd16;
  localparam int              ACC_WIDTH_DEF      = 32;

  typedef enum logic {
    CFG_IDLE,
    CFG_PENDING
  } cfg_state_e;

  // round(2^ACC_WIDTH * baud * os / clk_hz), evaluated in 64-bit integer math
  function automatic longint unsigned calc_inc(input longint unsigned clk_hz,
                                               input longint unsigned baud,
                                               input longint unsigned os);
    longint unsigned num;
    num = (64'd1 << ACC_WIDTH_DEF) * baud * os;
    return (num + clk_hz / 64'd2) / clk_hz;
  endfunction

  localparam longint unsigned DEFAULT_INC_VAL =
    calc_inc(CLK_HZ, DEFAULT_BAUD, DEFAULT_OVERSAMPLE);

endpackage

// File: rtl/nco_tick_generator_if.sv
// Control, config handshake and tick outputs of the NCO tick generator.
// The master side (UART / config host) drives the inputs; the generator is the slave.
interface nco_tick_generator_if #(
  parameter int ACC_WIDTH  = 32,
  parameter int OVERSAMPLE = 16
);
  localparam int PHASE_W = $clog2(OVERSAMPLE);

  logic                 en_in;
  logic                 resync_in;
  logic                 cfg_valid_in;
  logic [ACC_WIDTH-1:0] cfg_inc_in;
  logic                 cfg_ready_out;
  logic                 sample_tick_out;
  logic                 mid_tick_out;
  logic                 baud_tick;
  logic [PHASE_W-1:0]   phase_out;

  modport master (
    output en_in, resync_in, cfg_valid_in, cfg_inc_in,
    input  cfg_ready_out, sample_tick_out, mid_tick_out, baud_tick, phase_out
  );

  modport slave (
    input  en_in, resync_in, cfg_valid_in, cfg_inc_in,
    output cfg_ready_out, sample_tick_out, mid_tick_out, baud_tick, phase_out
  );
endinterface

// File: rtl/nco_tick_generator_phase_accumulator.sv
// Phase accumulator: acc advances by inc while enabled; the wrap carry is exposed
// combinationally (for same-edge decode) and as a registered one-cycle tick.
module phase_accumulator #(
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [ACC_WIDTH-1:0] inc,
  output logic                 carry,
  output logic                 carry_p1
);

  logic [ACC_WIDTH-1:0] acc_p1;
  logic [ACC_WIDTH:0]   sum_p0;

  assign sum_p0 = {1'b0, acc_p1} + {1'b0, inc};
  // A clear wins over a coincident wrap, so that carry never reaches the decode.
  assign carry  = en && !clr && sum_p0[ACC_WIDTH];

  // ---- stage p0 -> p1: accumulator and registered carry ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1   <= '0;
      carry_p1 <= 1'b0;
    end else if (clr) begin
      acc_p1   <= '0;
      carry_p1 <= 1'b0;
    end else begin
      carry_p1 <= carry;
      if (en) begin
        acc_p1 <= sum_p0[ACC_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/nco_tick_generator.sv
// NCO tick generator: sample ticks at OVERSAMPLE x baud plus aligned mid-bit and
// baud ticks, with a runtime increment applied only on a bit boundary.
module nco_tick_generator
  import tickgen_pkg::*;
#(
  parameter int                   ACC_WIDTH   = 32,
  parameter int                   OVERSAMPLE  = 16,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = ACC_WIDTH'(DEFAULT_INC_VAL)
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  nco_tick_generator_if.slave tick_bus
);

  localparam int                 PHASE_W    = $clog2(OVERSAMPLE);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [PHASE_W-1:0] PHASE_MID  = PHASE_W'(OVERSAMPLE / 2 - 1);

  if (OVERSAMPLE < 4 || OVERSAMPLE > 64 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("OVERSAMPLE must be a power of two in 4..64");
  end

  cfg_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] inc_q;
  logic [ACC_WIDTH-1:0] pending_inc_q;
  logic [PHASE_W-1:0]   phase_p1;
  logic                 mid_tick_p1;
  logic                 baud_tick_p1;
  logic                 carry;
  logic                 sample_tick_p1;
  logic                 take_cfg;
  logic                 apply_cfg;
  logic                 cfg_ready;

  phase_accumulator #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .en       (tick_bus.en_in),
    .clr      (tick_bus.resync_in),
    .inc      (inc_q),
    .carry    (carry),
    .carry_p1 (sample_tick_p1)
  );

  // ---- stage p0 -> p1: phase count and tick decode, aligned with the sample tick ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase_p1     <= '0;
      mid_tick_p1  <= 1'b0;
      baud_tick_p1 <= 1'b0;
    end else if (tick_bus.resync_in) begin
      phase_p1     <= '0;
      mid_tick_p1  <= 1'b0;
      baud_tick_p1 <= 1'b0;
    end else begin
      mid_tick_p1  <= carry && (phase_p1 == PHASE_MID);
      baud_tick_p1 <= carry && (phase_p1 == PHASE_LAST);
      if (carry) begin
        phase_p1 <= phase_p1 + PHASE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= CFG_IDLE;
      inc_q         <= DEFAULT_INC;
      pending_inc_q <= '0;
    end else begin
      state_q <= state_d;
      if (take_cfg) begin
        pending_inc_q <= tick_bus.cfg_inc_in;
      end
      if (apply_cfg) begin
        inc_q <= pending_inc_q;
      end
    end
  end

  // A pending rate waits for the bit boundary unless the bit timing is already void.
  always_comb begin
    state_d   = state_q;
    take_cfg  = 1'b0;
    apply_cfg = 1'b0;
    cfg_ready = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        cfg_ready = 1'b1;
        if (tick_bus.cfg_valid_in) begin
          take_cfg = 1'b1;
          state_d  = CFG_PENDING;
        end
      end
      CFG_PENDING: begin
        if (baud_tick_p1 || !tick_bus.en_in || tick_bus.resync_in) begin
          apply_cfg = 1'b1;
          state_d   = CFG_IDLE;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  assign tick_bus.cfg_ready_out   = cfg_ready;
  assign tick_bus.sample_tick_out = sample_tick_p1;
  assign tick_bus.mid_tick_out    = mid_tick_p1;
  assign tick_bus.baud_tick       = baud_tick_p1;
  assign tick_bus.phase_out       = phase_p1;

endmodule

// File: tb/tb_nco_tick_generator.sv
// Bench for nco_tick_generator: table-driven rate vectors, hand-written corner
// sequences, and a tick scoreboard keyed by clock edge number.
module tb_nco_tick_generator;
  import tickgen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int   edge_n = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  nco_tick_generator_if #(.ACC_WIDTH(32), .OVERSAMPLE(4))  tick_bus ();
  nco_tick_generator_if #(.ACC_WIDTH(32), .OVERSAMPLE(16)) tick_bus2 ();

  nco_tick_generator #(.ACC_WIDTH(32), .OVERSAMPLE(4)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .tick_bus (tick_bus)
  );

  nco_tick_generator #(.ACC_WIDTH(32), .OVERSAMPLE(16)) dut2 (
    .clk_in   (clk),
    .rst_n_in (rst2_n),
    .tick_bus (tick_bus2)
  );

  typedef struct {
    int         at;
    logic       s;
    logic       m;
    logic       b;
    logic [1:0] ph;
  } ev_t;

  typedef struct {
    logic [31:0] inc;
    int          period;
    int          n_ticks;
    int          run_edges;
  } vec_t;

  ev_t sb[$];
  ev_t mon_ev;
  vec_t vt[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_n);
  endtask

  // k-th sample tick after a resync: mid on k%4==2, baud on k%4==0
  task automatic push(input int at, input int k);
    ev_t e;
    e.at = at;
    e.s  = 1'b1;
    e.m  = (k % 4 == 2);
    e.b  = (k % 4 == 0);
    e.ph = 2'(k % 4);
    sb.push_back(e);
  endtask

  task automatic go(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic load_idle(input logic [31:0] v);
    int e;
    @(negedge clk);
    tick_bus.en_in        = 1'b0;
    tick_bus.resync_in    = 1'b0;
    tick_bus.cfg_valid_in = 1'b1;
    tick_bus.cfg_inc_in   = v;
    e = edge_n + 1;
    go(e);
    chk("cfg_ready_busy", tick_bus.cfg_ready_out, 1'b0);
    tick_bus.cfg_valid_in = 1'b0;
    go(e + 1);
    chk("cfg_ready_back", tick_bus.cfg_ready_out, 1'b1);
  endtask

  task automatic start(output int r);
    tick_bus.resync_in = 1'b1;
    tick_bus.en_in     = 1'b1;
    r = edge_n + 1;
    go(r);
    tick_bus.resync_in = 1'b0;
    chk("phase_after_resync", tick_bus.phase_out, 2'd0);
  endtask

  task automatic drain(input string name);
    go(edge_n + 2);
    chk(name, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (tick_bus.sample_tick_out || tick_bus.mid_tick_out || tick_bus.baud_tick) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_tick edge=%0d actual=tick required=none", edge_n);
      end else begin
        mon_ev = sb.pop_front();
        chk("tick_edge", edge_n, mon_ev.at);
        chk("tick_flags",
            {tick_bus.sample_tick_out, tick_bus.mid_tick_out, tick_bus.baud_tick, tick_bus.phase_out},
            {mon_ev.s, mon_ev.m, mon_ev.b, mon_ev.ph});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog edge=%0d actual=running required=finished", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int e0;
    int ns;
    int nm;
    int nb;

    vt[0] = '{32'h4000_0000, 4,  8, 32};
    vt[1] = '{32'h2000_0000, 8,  4, 32};
    vt[2] = '{32'h8000_0000, 2,  8, 16};
    vt[3] = '{32'h1000_0000, 16, 4, 64};
    vt[4] = '{32'h0000_0000, 0,  0, 40};

    tick_bus.en_in = 1'b0;  tick_bus.resync_in = 1'b0;
    tick_bus.cfg_valid_in = 1'b0;  tick_bus.cfg_inc_in = '0;
    tick_bus2.en_in = 1'b0; tick_bus2.resync_in = 1'b0;
    tick_bus2.cfg_valid_in = 1'b0; tick_bus2.cfg_inc_in = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", tick_bus.cfg_ready_out, 1'b1);
    chk("reset_ticks", {tick_bus.sample_tick_out, tick_bus.mid_tick_out, tick_bus.baud_tick}, 3'b000);
    chk("reset_phase", tick_bus.phase_out, 2'd0);
    chk("calc_inc_default", calc_inc(CLK_HZ, DEFAULT_BAUD, DEFAULT_OVERSAMPLE), 64'd79164837);
    @(negedge clk);
    rst_n = 1'b1;

    // Rate table: load with en low (applies next edge), resync, run whole bits.
    for (int i = 0; i < 5; i++) begin
      load_idle(vt[i].inc);
      start(r);
      for (int k = 1; k <= vt[i].n_ticks; k++) push(r + k * vt[i].period, k);
      go(r + vt[i].run_edges);
      tick_bus.en_in = 1'b0;
      drain("table_drained");
    end

    // Mid-bit rate change waits for the baud edge; a second offer while pending is ignored.
    load_idle(32'h4000_0000);
    start(r);
    push(r + 4, 1);  push(r + 8, 2);  push(r + 12, 3); push(r + 16, 4);
    push(r + 23, 5); push(r + 31, 6); push(r + 39, 7); push(r + 47, 8);
    go(r + 5);
    tick_bus.cfg_valid_in = 1'b1;
    tick_bus.cfg_inc_in   = 32'h2000_0000;
    go(r + 6);
    tick_bus.cfg_valid_in = 1'b0;
    chk("pending_ready_low", tick_bus.cfg_ready_out, 1'b0);
    go(r + 8);
    tick_bus.cfg_valid_in = 1'b1;
    tick_bus.cfg_inc_in   = 32'h8000_0000;
    go(r + 9);
    tick_bus.cfg_valid_in = 1'b0;
    go(r + 16);
    chk("ready_low_at_baud", tick_bus.cfg_ready_out, 1'b0);
    go(r + 17);
    chk("ready_after_baud", tick_bus.cfg_ready_out, 1'b1);
    go(r + 47);
    tick_bus.en_in = 1'b0;
    drain("rate_change_drained");

    // Resync on a carry edge swallows that tick and restarts the bit.
    load_idle(32'h4000_0000);
    start(r);
    push(r + 4, 1);
    go(r + 7);
    tick_bus.resync_in = 1'b1;
    go(r + 8);
    tick_bus.resync_in = 1'b0;
    chk("resync_phase", tick_bus.phase_out, 2'd0);
    chk("resync_no_tick", tick_bus.sample_tick_out, 1'b0);
    push(r + 12, 1); push(r + 16, 2); push(r + 20, 3); push(r + 24, 4);
    go(r + 24);
    tick_bus.en_in = 1'b0;
    drain("resync_drained");

    // Enable low for 10 edges mid-bit: phase holds, cadence resumes from it.
    start(r);
    push(r + 4, 1); push(r + 8, 2); push(r + 22, 3); push(r + 26, 4);
    go(r + 10);
    tick_bus.en_in = 1'b0;
    go(r + 15);
    chk("en_low_phase_held", tick_bus.phase_out, 2'd2);
    go(r + 20);
    tick_bus.en_in = 1'b1;
    go(r + 26);
    tick_bus.en_in = 1'b0;
    drain("enable_drained");

    // Asynchronous reset while a config is pending.
    load_idle(32'h4000_0000);
    start(r);
    push(r + 4, 1);
    go(r + 5);
    tick_bus.cfg_valid_in = 1'b1;
    tick_bus.cfg_inc_in   = 32'h2000_0000;
    go(r + 6);
    tick_bus.cfg_valid_in = 1'b0;
    chk("pre_reset_pending", tick_bus.cfg_ready_out, 1'b0);
    go(r + 7);
    @(posedge clk);
    #1;
    chk("pre_reset_ticks", {tick_bus.sample_tick_out, tick_bus.mid_tick_out}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_ticks", {tick_bus.sample_tick_out, tick_bus.mid_tick_out, tick_bus.baud_tick}, 3'b000);
    chk("async_reset_phase", tick_bus.phase_out, 2'd1 ^ 2'd1);
    chk("async_reset_ready", tick_bus.cfg_ready_out, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    e0 = edge_n;
    // DEFAULT_INC wraps on the 55th accumulation (54*inc < 2^32 <= 55*inc).
    push(e0 + 55, 1);
    go(e0 + 3);
    chk("post_reset_ready", tick_bus.cfg_ready_out, 1'b1);
    go(e0 + 55);
    tick_bus.en_in = 1'b0;
    drain("default_inc_drained");

    // Long run at the default rate with 16x oversampling.
    ns = 0; nm = 0; nb = 0;
    @(negedge clk);
    rst2_n = 1'b1;
    tick_bus2.en_in = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (tick_bus2.sample_tick_out) ns++;
      if (tick_bus2.mid_tick_out) nm++;
      if (tick_bus2.baud_tick) nb++;
    end
    chk("os16_sample_count", ns, 368);
    chk("os16_mid_count", nm, 23);
    chk("os16_baud_count", nb, 23);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
